// File: rtl/muntjac_pkg.sv
// rtl/muntjac_pkg.sv - shared frontend/decode types and instruction queue defaults
package muntjac_pkg;

  localparam int unsigned IQ_DEFAULT_DEPTH = 4;

  typedef enum logic [3:0] {
    IF_PREFETCH      = 4'd0,
    IF_PREDICT       = 4'd1,
    IF_MISPREDICT    = 4'd2,
    IF_PROT_CHANGED  = 4'd3,
    IF_SATP_CHANGED  = 4'd4,
    IF_FENCE_I       = 4'd5
  } if_reason_e;

  typedef enum logic [3:0] {
    EXC_CAUSE_INSN_ADDR_MISA     = 4'd0,
    EXC_CAUSE_INSTR_ACCESS_FAULT = 4'd1,
    EXC_CAUSE_ILLEGAL_INSN       = 4'd2,
    EXC_CAUSE_BREAKPOINT         = 4'd3,
    EXC_CAUSE_INSTR_PAGE_FAULT   = 4'd12
  } exc_cause_e;

  typedef struct packed {
    exc_cause_e  cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    if_reason_e  if_reason;
    logic [31:0] instr;
    logic        ex_valid;
    exception_t  exception;
  } fetched_instr_t;

endpackage

// File: rtl/muntjac_instr_queue.sv
// rtl/muntjac_instr_queue.sv - frontend-to-decode instruction FIFO with flush and exception block
// Optional empty-queue forwarding path enabled by MUNTJAC_IQ_BYPASS_EN.
module muntjac_instr_queue import muntjac_pkg::*; #(
  parameter int unsigned Depth = IQ_DEFAULT_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  fetched_instr_t             in_instr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output fetched_instr_t             out_instr_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       ex_blocked_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  fetched_instr_t  mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ex_blocked_q, ex_blocked_d;
  logic            bypass, enq, deq, push, pop;

  always_comb begin
`ifdef MUNTJAC_IQ_BYPASS_EN
    bypass = (count_q == '0) && !flush_i;
`else
    bypass = 1'b0;
`endif
    in_ready_o = (count_q != DepthCnt) && !ex_blocked_q;
    // Forwarded entries still respect the exception block, so no wrong-path entry leaks out.
    if (bypass) begin
      out_valid_o = in_valid_i && !ex_blocked_q;
      out_instr_o = in_instr_i;
    end else begin
      out_valid_o = (count_q != '0) && !flush_i;
      out_instr_o = mem_q[rd_ptr_q];
    end
    enq  = in_valid_i && in_ready_o && !flush_i;
    deq  = out_valid_o && out_ready_i && !flush_i;
    push = enq && !(bypass && out_ready_i);
    pop  = deq && !bypass;
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    ex_blocked_d = ex_blocked_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      ex_blocked_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
      if (enq && in_instr_i.ex_valid) ex_blocked_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ex_blocked_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ex_blocked_q <= ex_blocked_d;
    end
  end

  // Payload storage carries no reset; validity comes solely from the count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_instr_i;
  end

  assign count_o      = count_q;
  assign ex_blocked_o = ex_blocked_q;

endmodule

// File: tb/tb_muntjac_instr_queue.sv
// tb/tb_muntjac_instr_queue.sv - directed and randomized bench for the instruction queue
module tb_muntjac_instr_queue;
  import muntjac_pkg::*;

  localparam int DEPTH = 4;

  logic           clk_i;
  logic           rst_ni;
  logic           flush_i;
  logic           in_valid_i;
  logic           in_ready_o;
  fetched_instr_t in_instr_i;
  logic           out_valid_o;
  logic           out_ready_i;
  fetched_instr_t out_instr_o;
  logic [2:0]     count_o;
  logic           ex_blocked_o;

  muntjac_instr_queue #(.Depth(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_instr_i   (in_instr_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_instr_o  (out_instr_o),
    .count_o      (count_o),
    .ex_blocked_o (ex_blocked_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int             n_cmp = 0;
  int             n_err = 0;
  int             n_deq = 0;
  fetched_instr_t mq[$];
  logic           m_blk = 1'b0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic fetched_instr_t mk(input logic [63:0] pc, input logic exv);
    fetched_instr_t d;
    d.pc              = pc;
    d.if_reason       = if_reason_e'($urandom_range(0, 5));
    d.instr           = $urandom;
    d.ex_valid        = exv;
    d.exception.cause = ($urandom_range(0, 1) == 0) ? EXC_CAUSE_ILLEGAL_INSN : EXC_CAUSE_INSTR_PAGE_FAULT;
    d.exception.tval  = {$urandom, $urandom};
    return d;
  endfunction

  // One clock: drive, check against the reference queue, advance the model at the edge.
  task automatic cycle(input logic v, input logic r, input logic f, input fetched_instr_t d);
    logic exp_ir, exp_ov;
    in_valid_i  = v;
    out_ready_i = r;
    flush_i     = f;
    in_instr_i  = d;
    #1;
    exp_ir = (mq.size() < DEPTH) && !m_blk;
    exp_ov = (mq.size() != 0) && !f;
    chk("count", 200'(count_o), 200'(mq.size()));
    chk("in_ready", 200'(in_ready_o), 200'(exp_ir));
    chk("out_valid", 200'(out_valid_o), 200'(exp_ov));
    chk("ex_blocked", 200'(ex_blocked_o), 200'(m_blk));
    if (exp_ov) chk("out_instr", 200'(out_instr_o), 200'(mq[0]));
    @(posedge clk_i);
    if (f) begin
      mq.delete();
      m_blk = 1'b0;
    end else begin
      if (exp_ov && r) begin
        void'(mq.pop_front());
        n_deq++;
      end
      if (v && exp_ir) begin
        mq.push_back(d);
        if (d.ex_valid) m_blk = 1'b1;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    fetched_instr_t d;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_instr_i  = mk(64'h0, 1'b0);
    #1;
    chk("rst_in_ready", 200'(in_ready_o), 200'(1'b1));
    chk("rst_out_valid", 200'(out_valid_o), 200'(1'b0));
    chk("rst_count", 200'(count_o), 200'(0));
    chk("rst_ex_blocked", 200'(ex_blocked_o), 200'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, mk(64'h80000000 + 64'(4 * i), 1'b0));
    #1;
    chk("fill_count", 200'(count_o), 200'(4));
    chk("fill_in_ready", 200'(in_ready_o), 200'(1'b0));
    cycle(1'b1, 1'b0, 1'b0, mk(64'h90000000, 1'b0));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", 200'(out_instr_o.pc), 200'(64'h80000000 + 64'(4 * i)));
      cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));
    end
    #1;
    chk("drain_count", 200'(count_o), 200'(0));

    // Streaming
    n_deq = 0;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, mk(64'h80000100 + 64'(4 * i), 1'b0));
    #1;
    chk("stream_count", 200'(count_o), 200'(1));
    chk("stream_deq", 200'(n_deq), 200'(19));
    cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));

    // Flush with an incoming entry in the same cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, mk(64'h80000200 + 64'(4 * i), 1'b0));
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    #1;
    chk("flush_out_valid", 200'(out_valid_o), 200'(1'b0));
    cycle(1'b1, 1'b0, 1'b1, mk(64'h80000300, 1'b0));
    chk("post_flush_count", 200'(count_o), 200'(0));
    cycle(1'b1, 1'b0, 1'b0, mk(64'h80001000, 1'b0));
    #1;
    chk("post_flush_head", 200'(out_instr_o.pc), 200'(64'h80001000));
    cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));

    // Exception block
    d = mk(64'h80002000, 1'b1);
    d.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
    d.exception.tval  = 64'h80002000;
    cycle(1'b1, 1'b0, 1'b0, d);
    #1;
    chk("exc_blocked", 200'(ex_blocked_o), 200'(1'b1));
    chk("exc_in_ready", 200'(in_ready_o), 200'(1'b0));
    chk("exc_count", 200'(count_o), 200'(1));
    cycle(1'b1, 1'b0, 1'b0, mk(64'h80002004, 1'b0));
    #1;
    chk("exc_cause", 200'(out_instr_o.exception.cause), 200'(EXC_CAUSE_INSTR_PAGE_FAULT));
    chk("exc_tval", 200'(out_instr_o.exception.tval), 200'(64'h80002000));
    cycle(1'b1, 1'b1, 1'b0, mk(64'h80002008, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk(64'h8000200c, 1'b0));
    cycle(1'b0, 1'b0, 1'b1, mk(64'h0, 1'b0));
    chk("exc_cleared", 200'(ex_blocked_o), 200'(1'b0));

    // Wrap-around bursts
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, mk(64'h80003000 + 64'(12 * b + 4 * i), 1'b0));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0),
            mk(64'h80004000 + 64'(4 * i), 1'($urandom_range(0, 19) == 0)));
    end
    cycle(1'b0, 1'b0, 1'b1, mk(64'h0, 1'b0));

    // Asynchronous reset at occupancy 2
    cycle(1'b1, 1'b0, 1'b0, mk(64'h80005000, 1'b0));
    cycle(1'b1, 1'b0, 1'b0, mk(64'h80005004, 1'b0));
    #2;
    chk("pre_reset_count", 200'(count_o), 200'(2));
    rst_ni = 1'b0;
    #1;
    mq.delete();
    m_blk = 1'b0;
    chk("async_rst_count", 200'(count_o), 200'(0));
    chk("async_rst_out_valid", 200'(out_valid_o), 200'(1'b0));
    chk("async_rst_in_ready", 200'(in_ready_o), 200'(1'b1));
    chk("async_rst_ex_blocked", 200'(ex_blocked_o), 200'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));
    cycle(1'b1, 1'b0, 1'b0, mk(64'h80006000, 1'b0));
    cycle(1'b0, 1'b1, 1'b0, mk(64'h0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muntjac_instr_queue.md
# muntjac_instr_queue

Decoupling FIFO between the instruction frontend and the decode stage. It accepts `fetched_instr_t` entries from the frontend fetch handshake and presents them in order to decode. It isolates decode back-pressure from the I$/alignment pipeline, and discards all wrong-path entries on a pipeline redirect.

## Interface
Parameters:
- `Depth`, default 4: number of entries; power of two, ≥ 2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: discard all contents; driven by the same pulse as the frontend redirect valid.
- `in_valid_i`, in, 1: frontend has an instruction.
- `in_ready_o`, out, 1: queue accepts an instruction.
- `in_instr_i`, in, `fetched_instr_t`: incoming instruction.
- `out_valid_o`, out, 1: head entry valid.
- `out_ready_i`, in, 1: decode consumes the head.
- `out_instr_o`, out, `fetched_instr_t`: head entry.
- `count_o`, out, `$clog2(Depth+1)`: current occupancy.
- `ex_blocked_o`, out, 1: an exception entry has been accepted and enqueue is blocked.

## Operation
- Circular buffer of `Depth` entries with read pointer, write pointer and occupancy counter. Pointers are `$clog2(Depth)` bits and wrap naturally.
- Enqueue when `in_valid_i && in_ready_o && !flush_i`.
- Dequeue when `out_valid_o && out_ready_i && !flush_i`.
- `in_ready_o = (count < Depth) && !ex_blocked_q`.
  - There is no combinational path from `out_ready_i`, so a full queue does not accept in the same cycle it drains.
- `out_valid_o = count != 0`, unless bypass applies (see Configuration). `out_instr_o` = storage at the read pointer.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any occupancy from 1 to `Depth-1`.
- Exception block:
  - Accepting an entry with `ex_valid = 1` sets `ex_blocked_q`.
  - While it is set, `in_ready_o = 0`, because all later fetches are wrong-path.
  - Only `flush_i` or reset clears it. The exception entry itself still drains normally.
- Flush:
  - In the `flush_i` cycle, `out_valid_o` is forced 0 and the incoming entry is dropped.
  - At the next edge, both pointers, the count and `ex_blocked_q` become 0.
  - Flush has priority over every other event.
- Storage is not reset; only the control state is.

## Timing
- Reset values: `in_ready_o = 1`, `out_valid_o = 0`, `count_o = 0`, `ex_blocked_o = 0`. `out_instr_o` is don't-care.
- Latency without bypass: an entry accepted at edge N is visible on `out_valid_o` in cycle N+1.
- Throughput: one entry per cycle in each direction.
- Reset asserted mid-operation empties the queue immediately (asynchronous).
- After the `flush_i` cycle, the queue accepts entries in the very next cycle.

## Configuration
Macro `MUNTJAC_IQ_BYPASS_EN`.
- Defined:
  - When count == 0 and `!flush_i`, `in_instr_i` is forwarded combinationally: `out_valid_o = in_valid_i`, `out_instr_o = in_instr_i`.
  - If `out_ready_i` is also high, the entry is consumed without being written.
  - If `out_ready_i` is low, the entry is written as normal.
  - The exception-block rule still applies to bypassed exception entries.
  - Zero-cycle latency when empty.
- Not defined: no forwarding path; minimum latency 1 cycle; outputs depend only on registered state.

## Structure
- `fetched_instr_t`, `if_reason_e` and `exc_cause_e` come from `muntjac_pkg`.
- Add `localparam int unsigned IQ_DEFAULT_DEPTH = 4` to the package. The top-level core instantiates with it.
- No sub-module: storage, pointers and control live in this module. The block instantiates between the frontend's `fetch_valid_o`/`fetch_ready_i` and decode.

## Test plan
- Fill/drain: `Depth=4`, enqueue PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C with `out_ready_i = 0` -> `count_o = 4`, `in_ready_o = 0`. Then assert `out_ready_i` -> PCs emerge in order over 4 cycles; `count_o` returns to 0.
- Streaming: continuous `in_valid_i` and `out_ready_i` for 20 cycles with incrementing PCs -> one instruction out per cycle, no drops or duplicates. `count_o` stays at 1 without bypass and 0 with bypass.
- Flush: queue holds 3 entries, with `in_valid_i = 1` and `flush_i = 1` in the same cycle -> `out_valid_o = 0` that cycle. Next cycle `count_o = 0`; the next enqueued PC 0x80001000 is the first output.
- Exception block: enqueue an entry with `ex_valid = 1`, cause `EXC_CAUSE_INSTR_PAGE_FAULT`, tval 0x80002000 -> `ex_blocked_o = 1` and `in_ready_o = 0` despite free space. The entry drains with cause and tval intact; a flush clears the block.
- Wrap-around: 10 alternating bursts of 3 enqueues then 3 dequeues -> pointers wrap past `Depth-1`; data order is preserved.
- Async reset at `count_o = 2` -> all outputs take their reset values immediately; no stale entry appears after reset deasserts.
